// File: rtl/mem_arb_pkg.sv
// Shared defaults and types for the two-requester data-memory port arbiter.
package mem_arb_pkg;
  localparam int ARB_AW       = 15;
  localparam int ARB_DW       = 16;
  localparam int ARB_LAT      = 2;
  localparam int ARB_MAX_WAIT = 4;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_AUX = 1'b1
  } req_id_e;

  typedef struct packed {
    logic               valid;
    req_id_e            id;
    logic [ARB_AW-1:0]  addr;
  } tag_t;
endpackage

// File: rtl/mem_arb_tagpipe.sv
// Tracks in-flight reads for LAT cycles: the head routes returning data, and any
// valid entry whose address matches a pending write blocks that write.
module mem_arb_tagpipe
  import mem_arb_pkg::*;
#(
  parameter int LAT = ARB_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  tag_t              i_push,
  input  logic [ARB_AW-1:0] i_addr0,
  input  logic [ARB_AW-1:0] i_addr1,
  output logic              o_head_vld,
  output req_id_e           o_head_id,
  output logic              o_match0,
  output logic              o_match1
);
  tag_t r_pipe [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_push;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_head_vld = r_pipe[LAT-1].valid;
  assign o_head_id  = r_pipe[LAT-1].id;

  always_comb begin
    o_match0 = 1'b0;
    o_match1 = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (r_pipe[i].valid && (r_pipe[i].addr == i_addr0)) o_match0 = 1'b1;
      if (r_pipe[i].valid && (r_pipe[i].addr == i_addr1)) o_match1 = 1'b1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the pipeline (fixed priority) and an auxiliary
// reader that is forced ahead after MAX_WAIT denied cycles; reads return in issue order.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = ARB_AW,
  parameter int DW       = ARB_DW,
  parameter int LAT      = ARB_LAT,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata
);
  localparam int            WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] r_wait;
  logic [AW-1:0] r_raddr;

  logic          w_match0, w_match1;
  logic          w_head_vld;
  req_id_e       w_head_id;
  logic          w_ok0, w_ok1, w_force;
  logic          w_gnt0, w_gnt1, w_any, w_we, w_rd, w_wen;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  tag_t          w_push;

  // A write is eligible only when no in-flight read targets the same word.
  assign w_ok0   = req0 & ~(we0 & w_match0);
  assign w_ok1   = req1 & ~(we1 & w_match1);
  assign w_force = (r_wait == WAIT_MAX) & req1;
  assign w_gnt1  = w_ok1 & (w_force | ~w_ok0);
  assign w_gnt0  = w_ok0 & ~w_gnt1;

  assign w_any   = w_gnt0 | w_gnt1;
  assign w_we    = w_gnt1 ? we1    : we0;
  assign w_addr  = w_gnt1 ? addr1  : addr0;
  assign w_wdata = w_gnt1 ? wdata1 : wdata0;
  assign w_rd    = w_any & ~w_we;
  assign w_wen   = w_any & w_we;

  always_comb begin
    w_push       = '0;
    w_push.valid = w_rd;
    w_push.id    = w_gnt1 ? REQ_AUX : REQ_CPU;
    w_push.addr  = w_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (!req1 || w_gnt1) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr <= '0;
    end else if (w_rd) begin
      r_raddr <= w_addr;
    end
  end

  mem_arb_tagpipe #(
    .LAT (LAT)
  ) u_tagpipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_addr0    (addr0),
    .i_addr1    (addr1),
    .o_head_vld (w_head_vld),
    .o_head_id  (w_head_id),
    .o_match0   (w_match0),
    .o_match1   (w_match1)
  );

  // Grants and memory strobes stay quiet while reset is held, even with requests up.
  assign gnt0      = rst_n & w_gnt0;
  assign gnt1      = rst_n & w_gnt1;
  assign mem_wen   = rst_n & w_wen;
  assign mem_waddr = (rst_n & w_wen) ? w_addr  : '0;
  assign mem_wdata = (rst_n & w_wen) ? w_wdata : '0;
  assign mem_raddr = (rst_n & w_rd)  ? w_addr  : r_raddr;

  assign rvalid0 = w_head_vld & (w_head_id == REQ_CPU);
  assign rvalid1 = w_head_vld & (w_head_id == REQ_AUX);
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single data-memory port (one read or one write per cycle, fixed 2-cycle read latency) between two requesters: requester 0 (pipeline load/store/misaligned-fetch unit) and requester 1 (auxiliary loader/debug reader). Requester 0 has fixed priority. Requester 1 is guaranteed a grant after a bounded wait. Returned read data is routed to its issuer by a tag pipeline, and a write that would race an in-flight read to the same address is held off.

## Interface
- AW, 15, word-address width (byte address bits [15:1])
- DW, 16, data width
- LAT, 2, memory read latency in cycles (≥1)
- MAX_WAIT, 4, consecutive denied cycles after which requester 1 is forced ahead of requester 0 (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  request valid, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  combinational grant; the transfer happens on the edge where req&gnt=1
- rvalid0 / rvalid1  out  1  read data valid for that requester
- rdata0 / rdata1  out  DW  read data (both = mem_rdata; qualify with rvalid)
- mem_raddr  out  AW  memory read address
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_raddr
- mem_wen  out  1  memory write enable
- mem_waddr  out  AW  memory write address
- mem_wdata  out  DW  memory write data

## Operation
- At most one grant per cycle. gnt0 and gnt1 are never both 1. No grant is issued without a request.
- Priority: req0 wins, except when wait_cnt == MAX_WAIT and req1=1. In that case gnt1=1 and gnt0=0.
- wait_cnt (0..MAX_WAIT) behaviour:
  - increments when req1=1 and not granted, saturating at MAX_WAIT;
  - clears on a gnt1 transfer or when req1=0.
- Hazard hold: a write candidate is not granted if any valid tag-pipe entry holds the same address.
  - When the write is from requester 0 and is held, requester 1 is granted that cycle if it is requesting and is not itself a held write.
  - A held requester does not bump wait_cnt if it is requester 0.
- Granted read:
  - mem_raddr = granted addr;
  - push {valid=1, id, addr} into the tag pipe;
  - the data returns as rvalid[id]=1 exactly LAT cycles later.
- Granted write: mem_wen=1, mem_waddr and mem_wdata = granted fields, in the same cycle as the grant. No response is returned.
- Idle cycle: mem_wen=0, a tag-pipe bubble is pushed, and mem_raddr holds its last value.
- Ordering: a read returns memory contents including every write granted in an earlier cycle and no write granted later.

## Timing
- Reset values: gnt0=gnt1=0, rvalid0=rvalid1=0, mem_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0, wait_cnt=0, tag pipe all invalid.
- Read latency: grant at edge T, so rvalid high during cycle T+LAT for exactly 1 cycle.
- Back-to-back reads are fully pipelined at one per cycle. Mixed-requester reads return in issue order.
- Write followed by a read to the same address in the next cycle: the read is granted immediately and returns the new data.
- Read followed by a write to the same address: the write is held LAT cycles. It is granted in the cycle after the read's rvalid.
- Reset asserted mid-operation: all in-flight reads are discarded. No rvalid appears after rst_n deasserts until a new read is granted.
- req deassertion before grant is legal; the request is simply dropped.

## Structure
- Package mem_arb_pkg:
  - AW, DW, LAT defaults;
  - requester id type (REQ_CPU=0, REQ_AUX=1);
  - tag record {valid, id, addr}.
- Sub-module mem_arb_tagpipe: LAT-deep shift register of tag records.
  - Outputs the head entry for rvalid routing.
  - Outputs a combinational "address match in any valid entry" for the hazard hold.
- Top holds the priority/forcing logic, wait_cnt and output muxing.

## Test plan
- Reset: hold rst_n=0 with req0=req1=1. Required: all outputs 0. After release, the first grant goes to req0.
- Latency and routing: req0 read 0x0010 (mem holds 0xBEEF), then req1 read 0x0011 (0x1234) the next cycle. Required: rvalid0 with 0xBEEF at T+2, then rvalid1 with 0x1234 at T+3.
- Starvation: req0 and req1 held continuously, MAX_WAIT=4. Required grant pattern: gnt0 ×4, gnt1 ×1, repeating.
- Hazard: req1 read 0x0020 (0x0001), then req0 write 0x0020=0x00FF the next cycle. Required:
  - write held 2 cycles;
  - rvalid1 returns 0x0001;
  - a later read returns 0x00FF.
- Write-then-read: req0 write 0x0030=0xAAAA, then req0 read 0x0030 the next cycle. Required: no hold, and 0xAAAA returned 2 cycles later.
- Reset mid-flight: grant a read, then assert rst_n low the next cycle for 1 cycle. Required: no rvalid at any point afterwards.
